channel_data_xfer: RTL and testbench

- Channel-side data-phase engine for the parallel channel "A" bus; sits between the AXI byte DMA path and the bus tag/data pins.
- Moves a counted run of bytes over the interlocked service_in/service_out handshake, in either direction.
  - Write (channel to device): consumes a byte stream and drives bus_out.
  - Read (device to channel): captures bus_in and produces a byte stream.
- Ends the data phase on status_in. When the count is exhausted, it answers service_in with command_out (stop).

---
 rtl/channel_data_xfer.sv | 213 +++++++++++++++++++++
 tb/tb_channel_data_xfer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_data_xfer.sv
// ---------------------------------------------------------------------------
// channel_data_xfer
//   Channel-side data-phase engine for the parallel channel "A" bus. Moves a
//   counted run of bytes over the interlocked service_in/service_out tag
//   handshake, channel-to-device (write) or device-to-channel (read). The data
//   phase ends on status_in; once the count is exhausted the next service_in
//   is answered with command_out (stop).
//
// Ports
//   aclk, reset          clock, synchronous active-high reset
//   start/write/count    transfer request (start is a one-cycle pulse)
//   busy/done            transfer in progress / one-cycle end pulse
//   residual/stopped     remaining count and stop flag, valid from done
//   wr_t*                write-direction byte stream (consumed)
//   rd_t*                read-direction byte stream (produced)
//   bus_in, service_in,
//   status_in            asynchronous device-side bus and tags
//   bus_out, service_out,
//   command_out          channel-side bus and tags
// ---------------------------------------------------------------------------
module channel_data_xfer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic        start,
    input  logic        write,
    input  logic [15:0] count,
    output logic        busy,
    output logic        done,
    output logic [15:0] residual,
    output logic        stopped,
    input  logic [7:0]  wr_tdata,
    input  logic        wr_tvalid,
    output logic        wr_tready,
    output logic [7:0]  rd_tdata,
    output logic        rd_tvalid,
    input  logic        rd_tready,
    input  logic [7:0]  bus_in,
    input  logic        service_in,
    input  logic        status_in,
    output logic [7:0]  bus_out,
    output logic        service_out,
    output logic        command_out
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WFETCH,
        S_WDRIVE,
        S_RHOLD,
        S_DROP,
        S_STOP,
        S_FIN
    } state_t;

    // -----------------------------------------------------------------------
    // Synchronisers. bus_in goes through a plain multi-bit chain of the same
    // depth as service_in: the device holds the bus stable before raising
    // service_in and until service_out answers, so bus_s is settled whenever
    // svc_s is seen high.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0]      svc_sync_q;
    logic [SYNC_STAGES-1:0]      sts_sync_q;
    logic [SYNC_STAGES-1:0][7:0] bus_sync_q;
    logic                        svc_s;
    logic                        sts_s;
    logic [7:0]                  bus_s;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the
    // synchroniser chain into a single stage.
    always_ff @(posedge aclk) begin
        if (reset) begin
            svc_sync_q <= '0;
            sts_sync_q <= '0;
            bus_sync_q <= '0;
        end else begin
            svc_sync_q <= {svc_sync_q[SYNC_STAGES-2:0], service_in};
            sts_sync_q <= {sts_sync_q[SYNC_STAGES-2:0], status_in};
            bus_sync_q <= {bus_sync_q[SYNC_STAGES-2:0], bus_in};
        end
    end

    assign svc_s = svc_sync_q[SYNC_STAGES-1];
    assign sts_s = sts_sync_q[SYNC_STAGES-1];
    assign bus_s = bus_sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Data-phase FSM with registered outputs
    // -----------------------------------------------------------------------
    state_t      state_q;
    logic        write_q;
    logic [15:0] cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] residual_q;
    logic        stopped_q;
    logic [7:0]  rd_tdata_q;
    logic        rd_tvalid_q;
    logic [7:0]  bus_out_q;
    logic        service_q;
    logic        command_q;

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            residual_q  <= '0;
            stopped_q   <= 1'b0;
            rd_tdata_q  <= '0;
            rd_tvalid_q <= 1'b0;
            bus_out_q   <= '0;
            service_q   <= 1'b0;
            command_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        write_q   <= write;
                        cnt_q     <= count;
                        busy_q    <= 1'b1;
                        stopped_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Status wins over a simultaneous service request.
                    if (sts_s) begin
                        state_q <= S_FIN;
                    end else if (svc_s) begin
                        if (cnt_q == '0) begin
                            command_q <= 1'b1;
                            stopped_q <= 1'b1;
                            state_q   <= S_STOP;
                        end else if (write_q) begin
                            state_q <= S_WFETCH;
                        end else begin
                            rd_tdata_q  <= bus_s;
                            rd_tvalid_q <= 1'b1;
                            state_q     <= S_RHOLD;
                        end
                    end
                end
                S_WFETCH: begin
                    if (wr_tvalid) begin
                        bus_out_q <= wr_tdata;
                        cnt_q     <= cnt_q - 16'd1;
                        state_q   <= S_WDRIVE;
                    end
                end
                S_WDRIVE: begin
                    // One cycle of bus setup before the tag rises.
                    service_q <= 1'b1;
                    state_q   <= S_DROP;
                end
                S_RHOLD: begin
                    if (rd_tready) begin
                        rd_tvalid_q <= 1'b0;
                        cnt_q       <= cnt_q - 16'd1;
                        service_q   <= 1'b1;
                        state_q     <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (!svc_s) begin
                        service_q <= 1'b0;
                        bus_out_q <= '0;
                        state_q   <= S_WAIT;
                    end
                end
                S_STOP: begin
                    if (!svc_s) begin
                        command_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end
                end
                S_FIN: begin
                    residual_q <= cnt_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Combinational accept: only while fetching a write byte.
    assign wr_tready   = (state_q == S_WFETCH) && wr_tvalid;

    assign busy        = busy_q;
    assign done        = done_q;
    assign residual    = residual_q;
    assign stopped     = stopped_q;
    assign rd_tdata    = rd_tdata_q;
    assign rd_tvalid   = rd_tvalid_q;
    assign bus_out     = bus_out_q;
    assign service_out = service_q;
    assign command_out = command_q;

endmodule

// File: tb/tb_channel_data_xfer.sv
// ---------------------------------------------------------------------------
// tb_channel_data_xfer
//   Drives channel_data_xfer with a behavioural device (service/status tags)
//   and AXI-style byte source/sink. Expected bytes are queued when offered and
//   compared when the DUT moves them.
// ---------------------------------------------------------------------------
module tb_channel_data_xfer;

    logic        aclk;
    logic        reset;
    logic        start;
    logic        write;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [15:0] residual;
    logic        stopped;
    logic [7:0]  wr_tdata;
    logic        wr_tvalid;
    logic        wr_tready;
    logic [7:0]  rd_tdata;
    logic        rd_tvalid;
    logic        rd_tready;
    logic [7:0]  bus_in;
    logic        service_in;
    logic        status_in;
    logic [7:0]  bus_out;
    logic        service_out;
    logic        command_out;

    channel_data_xfer #(.SYNC_STAGES(2)) dut (
        .aclk(aclk), .reset(reset), .start(start), .write(write), .count(count),
        .busy(busy), .done(done), .residual(residual), .stopped(stopped),
        .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready),
        .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready),
        .bus_in(bus_in), .service_in(service_in), .status_in(status_in),
        .bus_out(bus_out), .service_out(service_out), .command_out(command_out)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    logic [7:0] wr_src[$];   // bytes offered on the write stream
    logic [7:0] exp_wr[$];   // bytes expected on bus_out
    logic [7:0] exp_rd[$];   // bytes expected on rd_tdata
    logic       tb_write = 1'b0;
    int         done_cnt = 0;
    int         rd_acc_cnt = 0;
    logic       svc_prev = 1'b0;
    logic [7:0] bus_prev = 8'h00;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Write-stream source: pops a byte after each accepting edge.
    initial begin
        logic take;
        wr_tvalid = 1'b0;
        wr_tdata  = 8'h00;
        forever begin
            @(negedge aclk);
            take = wr_tready;
            @(posedge aclk);
            #1;
            if (take && wr_src.size() > 0) void'(wr_src.pop_front());
            wr_tvalid = (wr_src.size() > 0);
            wr_tdata  = wr_tvalid ? wr_src[0] : 8'h00;
        end
    end

    // Monitors, sampled mid-cycle.
    always @(negedge aclk) begin
        if (service_out && !svc_prev && tb_write) begin
            check("wr_setup", {24'h0, bus_out}, {24'h0, bus_prev});
            if (exp_wr.size() > 0) check("wr_byte", {24'h0, bus_out}, {24'h0, exp_wr.pop_front()});
            else check("wr_extra_byte", 32'd1, 32'd0);
        end
        if (service_out || command_out)
            check("tag_excl", {31'h0, service_out & command_out}, 32'd0);
        if (rd_tvalid && rd_tready) begin
            rd_acc_cnt++;
            if (exp_rd.size() > 0) check("rd_byte", {24'h0, rd_tdata}, {24'h0, exp_rd.pop_front()});
            else check("rd_extra_byte", 32'd1, 32'd0);
        end
        if (done) done_cnt++;
        svc_prev = service_out;
        bus_prev = bus_out;
    end

    task automatic start_xfer(input logic w, input logic [15:0] c);
        tb_write = w;
        write    = w;
        count    = c;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("busy_after_start", {31'h0, busy}, 32'd1);
    endtask

    // One device service request; reports the tags and bus seen at response.
    task automatic dev_service(input logic [7:0] b, output logic stop_o,
                               output logic svc_o, output logic [7:0] bus_o);
        bus_in = b;
        tick();
        service_in = 1'b1;
        for (int i = 0; i < 60 && !(service_out || command_out); i++) tick();
        if (!(service_out || command_out)) check("svc_resp_timeout", 32'd0, 32'd1);
        stop_o = command_out;
        svc_o  = service_out;
        bus_o  = bus_out;
        service_in = 1'b0;
        for (int i = 0; i < 60 && (service_out || command_out); i++) tick();
        if (service_out || command_out) check("svc_drop_timeout", 32'd0, 32'd1);
        bus_in = 8'h00;
    endtask

    // Present status (optionally together with service) and wait for done.
    task automatic dev_status(input logic with_svc);
        status_in = 1'b1;
        if (with_svc) service_in = 1'b1;
        for (int i = 0; i < 60 && !done; i++) tick();
        if (!done) check("done_timeout", 32'd0, 32'd1);
        status_in  = 1'b0;
        service_in = 1'b0;
        repeat (5) tick();
        check("busy_after_done", {31'h0, busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"},
              {25'h0, busy, done, stopped, wr_tready, rd_tvalid, service_out, command_out}, 32'd0);
        check({tag, "_data"}, {residual, rd_tdata, bus_out}, 32'd0);
    endtask

    initial begin
        logic       stp;
        logic       svc;
        logic [7:0] bo;
        int         d0;
        int         r0;

        reset = 1'b1; start = 1'b0; write = 1'b0; count = '0;
        rd_tready = 1'b1; bus_in = '0; service_in = 1'b0; status_in = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) tick();

        // Write three bytes, then status.
        d0 = done_cnt;
        foreach (wr_src[i]) ;
        wr_src.push_back(8'hA5); wr_src.push_back(8'h5A); wr_src.push_back(8'hFF);
        exp_wr.push_back(8'hA5); exp_wr.push_back(8'h5A); exp_wr.push_back(8'hFF);
        start_xfer(1'b1, 16'd3);
        dev_service(8'h00, stp, svc, bo);
        dev_service(8'h00, stp, svc, bo);
        dev_service(8'h00, stp, svc, bo);
        dev_status(1'b0);
        check("w3_residual", {16'h0, residual}, 32'd0);
        check("w3_stopped", {31'h0, stopped}, 32'd0);
        check("w3_done_pulses", done_cnt - d0, 32'd1);
        check("w3_all_bytes", exp_wr.size(), 32'd0);

        // Read two bytes, consumer stalls the first for five cycles.
        rd_tready = 1'b0;
        exp_rd.push_back(8'h3C);
        start_xfer(1'b0, 16'd2);
        fork
            dev_service(8'h3C, stp, svc, bo);
            begin
                for (int i = 0; i < 60 && !rd_tvalid; i++) tick();
                if (!rd_tvalid) check("rd_valid_timeout", 32'd0, 32'd1);
                for (int i = 0; i < 5; i++) begin
                    check("rd_hold_data", {24'h0, rd_tdata}, 32'h3C);
                    check("rd_hold_svc", {31'h0, service_out}, 32'd0);
                    tick();
                end
                rd_tready = 1'b1;
            end
        join
        exp_rd.push_back(8'hC3);
        dev_service(8'hC3, stp, svc, bo);
        dev_status(1'b0);
        check("r2_residual", {16'h0, residual}, 32'd0);
        check("r2_all_bytes", exp_rd.size(), 32'd0);

        // Write one byte, device asks twice: second gets a stop.
        wr_src.push_back(8'h77);
        exp_wr.push_back(8'h77);
        start_xfer(1'b1, 16'd1);
        dev_service(8'h00, stp, svc, bo);
        check("w1_first_not_stop", {31'h0, stp}, 32'd0);
        dev_service(8'h00, stp, svc, bo);
        check("w1_stop", {31'h0, stp}, 32'd1);
        check("w1_stop_svc", {31'h0, svc}, 32'd0);
        check("w1_stop_bus", {24'h0, bo}, 32'd0);
        dev_status(1'b0);
        check("w1_stopped", {31'h0, stopped}, 32'd1);
        check("w1_residual", {16'h0, residual}, 32'd0);

        // Read count 4, status after one byte.
        exp_rd.push_back(8'h11);
        start_xfer(1'b0, 16'd4);
        dev_service(8'h11, stp, svc, bo);
        dev_status(1'b0);
        check("r4_residual", {16'h0, residual}, 32'd3);
        check("r4_stopped", {31'h0, stopped}, 32'd0);

        // Service and status together in WAIT: status wins, nothing captured.
        r0 = rd_acc_cnt;
        d0 = done_cnt;
        bus_in = 8'h99;
        start_xfer(1'b0, 16'd4);
        dev_status(1'b1);
        bus_in = 8'h00;
        check("both_no_capture", rd_acc_cnt - r0, 32'd0);
        check("both_residual", {16'h0, residual}, 32'd4);
        check("both_done", done_cnt - d0, 32'd1);

        // Reset while driving a write byte.
        wr_src.push_back(8'h42);
        exp_wr.push_back(8'h42);
        start_xfer(1'b1, 16'd2);
        service_in = 1'b1;
        for (int i = 0; i < 60 && !wr_tready; i++) tick();
        if (!wr_tready) check("wr_ready_timeout", 32'd0, 32'd1);
        tick();
        check("wdrive_bus", {24'h0, bus_out}, 32'h42);
        check("wdrive_svc", {31'h0, service_out}, 32'd0);
        d0 = done_cnt;
        reset = 1'b1;
        service_in = 1'b0;
        tick();
        check_all_zero("mid_reset");
        exp_wr.delete();
        reset = 1'b0;
        repeat (2) tick();
        check("mid_reset_no_done", done_cnt - d0, 32'd0);
        start_xfer(1'b1, 16'd2);
        dev_status(1'b0);
        check("post_reset_residual", {16'h0, residual}, 32'd2);

        // start while busy is ignored.
        exp_rd.push_back(8'hAB);
        start_xfer(1'b0, 16'd2);
        write = 1'b1; count = 16'd9; start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_restart", {31'h0, busy}, 32'd1);
        dev_service(8'hAB, stp, svc, bo);
        dev_status(1'b0);
        check("ignored_start_residual", {16'h0, residual}, 32'd1);
        check("ignored_start_bytes", exp_rd.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
